// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - controller states, coin values and width helper for the vending controller
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE,
    REFUND
  } state_t;

  localparam logic [2:0] NICKEL_V  = 3'd1;
  localparam logic [2:0] DIME_V    = 3'd2;
  localparam logic [2:0] QUARTER_V = 3'd5;

  // Select width that stays legal for a single-item machine
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/change_pay.sv
// rtl/change_pay.sv - nickel payout counter shared by change return and refund
module change_pay #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_count,
  output logic         nickel_out,
  output logic         done
);

  logic [W-1:0] count;

  // After a load, pay one nickel per cycle until the loaded count is exhausted
  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      nickel_out <= 1'b0;
    end else if (load) begin
      count      <= load_count;
      nickel_out <= 1'b0;
    end else if (count != '0) begin
      count      <= count - 1'b1;
      nickel_out <= 1'b1;
    end else begin
      nickel_out <= 1'b0;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - multi-item vending controller top; VEND_REFUND_EN adds the cancel port and REFUND path
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int                            NUM_ITEMS  = 3,
  parameter int                            CREDIT_W   = 4,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {4'd6, 4'd5, 4'd4},
  parameter int                            MAX_CREDIT = 15,
  localparam int                           SEL_W      = sel_width(NUM_ITEMS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                nickel_in,
  input  logic                dime_in,
  input  logic                quarter_in,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
`ifdef VEND_REFUND_EN
  input  logic                cancel,
`endif
  output logic                coin_reject,
  output logic                dispense,
  output logic [SEL_W-1:0]    item_out,
  output logic                nickel_out,
  output logic [CREDIT_W-1:0] credit
);

  localparam int SUM_W = CREDIT_W + 1;

  state_t              state, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic                sel_held, sel_held_d;
  logic [SEL_W-1:0]    sel_q, sel_q_d;
  logic                dispense_d;
  logic [SEL_W-1:0]    item_d;
  logic                coin_reject_d;
  logic [CREDIT_W-1:0] price;
  logic [2:0]          coin_val;
  logic                coin_any;
  logic                coin_multi;
  logic                coin_ok;
  logic [SUM_W-1:0]    coin_sum;
  logic                collecting;
  logic                vend_ok;
  logic                sel_ok;
  logic                cancel_req;
  logic                pay_load;
  logic [CREDIT_W-1:0] pay_count;
  logic                pay_done;

`ifdef VEND_REFUND_EN
  assign cancel_req = cancel && (state == COLLECT);
`else
  assign cancel_req = 1'b0;
`endif

  // Price of the held selection
  always_comb begin
    price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_q == SEL_W'(i)) price = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
    end
  end

  // Highest-value strobe wins when several coins arrive together
  always_comb begin
    coin_val = 3'd0;
    if (quarter_in)     coin_val = QUARTER_V;
    else if (dime_in)   coin_val = DIME_V;
    else if (nickel_in) coin_val = NICKEL_V;
  end

  assign coin_any   = nickel_in | dime_in | quarter_in;
  assign coin_multi = (nickel_in & dime_in) | (nickel_in & quarter_in) | (dime_in & quarter_in);
  assign coin_sum   = SUM_W'(credit) + SUM_W'(coin_val);
  assign collecting = (state == IDLE) || (state == COLLECT);
  assign coin_ok    = coin_any && collecting && !cancel_req && (coin_sum <= SUM_W'(MAX_CREDIT));
  assign vend_ok    = (state == COLLECT) && sel_held && (credit >= price);
  assign sel_ok     = sel_valid && ($unsigned(32'(sel)) < $unsigned(NUM_ITEMS));

  // Next state, next credit/selection and next values of the registered pulses
  always_comb begin
    state_d       = state;
    credit_d      = credit;
    sel_held_d    = sel_held;
    sel_q_d       = sel_q;
    dispense_d    = 1'b0;
    item_d        = '0;
    coin_reject_d = coin_multi || (coin_any && !coin_ok);
    pay_load      = 1'b0;
    pay_count     = '0;
    case (state)
      IDLE, COLLECT: begin
        if (coin_ok) credit_d = coin_sum[CREDIT_W-1:0];
        if (cancel_req) begin
          state_d    = REFUND;
          sel_held_d = 1'b0;
          pay_load   = 1'b1;
          pay_count  = credit;
        end else if (vend_ok) begin
          // Selection is frozen on the way into VEND so the price used there matches
          state_d    = VEND;
          dispense_d = 1'b1;
          item_d     = sel_q;
        end else begin
          if (sel_ok) begin
            sel_held_d = 1'b1;
            sel_q_d    = sel;
          end
          state_d = ((credit_d != '0) || sel_held_d) ? COLLECT : IDLE;
        end
      end
      VEND: begin
        credit_d   = credit - price;
        sel_held_d = 1'b0;
        if (credit_d != '0) begin
          state_d   = CHANGE;
          pay_load  = 1'b1;
          pay_count = credit_d;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE, REFUND: begin
        // Credit tracks the payout: one nickel off per pulse
        if (!pay_done) credit_d = credit - 1'b1;
        else           state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Credit, held selection and registered output pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      credit      <= '0;
      sel_held    <= 1'b0;
      sel_q       <= '0;
      dispense    <= 1'b0;
      item_out    <= '0;
      coin_reject <= 1'b0;
    end else begin
      credit      <= credit_d;
      sel_held    <= sel_held_d;
      sel_q       <= sel_q_d;
      dispense    <= dispense_d;
      item_out    <= item_d;
      coin_reject <= coin_reject_d;
    end
  end

  change_pay #(
    .W(CREDIT_W)
  ) u_pay (
    .clock      (clock),
    .reset      (reset),
    .load       (pay_load),
    .load_count (pay_count),
    .nickel_out (nickel_out),
    .done       (pay_done)
  );

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - table-driven scoreboard bench for vend_ctrl; VEND_REFUND_EN adds refund sequences
module tb_vend_ctrl;

  typedef struct {
    logic       rst;
    logic       n;
    logic       d;
    logic       q;
    logic       sv;
    logic [1:0] s;
    logic       cn;
    logic       rej;
    logic       disp;
    logic [1:0] item;
    logic       nout;
    logic [3:0] cred;
  } vec_t;

  typedef struct packed {
    logic       rej;
    logic       disp;
    logic [1:0] item;
    logic       nout;
    logic [3:0] cred;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       nickel_in;
  logic       dime_in;
  logic       quarter_in;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       coin_reject;
  logic       dispense;
  logic [1:0] item_out;
  logic       nickel_out;
  logic [3:0] credit;

  int   passed;
  int   total;
  exp_t exp_q[$];
  vec_t vecs[$];

  vend_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .nickel_in   (nickel_in),
    .dime_in     (dime_in),
    .quarter_in  (quarter_in),
    .sel_valid   (sel_valid),
    .sel         (sel),
`ifdef VEND_REFUND_EN
    .cancel      (cancel),
`endif
    .coin_reject (coin_reject),
    .dispense    (dispense),
    .item_out    (item_out),
    .nickel_out  (nickel_out),
    .credit      (credit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic n, input logic d, input logic q,
                              input logic sv, input logic [1:0] s, input logic cn,
                              input logic rej, input logic disp, input logic [1:0] item,
                              input logic nout, input logic [3:0] cred);
    vec_t v;
    v.rst = rst; v.n = n; v.d = d; v.q = q; v.sv = sv; v.s = s; v.cn = cn;
    v.rej = rej; v.disp = disp; v.item = item; v.nout = nout; v.cred = cred;
    return v;
  endfunction

  // Drive one cycle of inputs, queue its expectation, then compare after the edge
  task automatic apply(input string name, input int idx, input vec_t v);
    exp_t want;
    exp_t got;
    reset = v.rst; nickel_in = v.n; dime_in = v.d; quarter_in = v.q;
    sel_valid = v.sv; sel = v.s; cancel = v.cn;
    exp_q.push_back('{v.rej, v.disp, v.item, v.nout, v.cred});
    @(posedge clock);
    #1;
    got  = '{coin_reject, dispense, item_out, nickel_out, credit};
    want = exp_q.pop_front();
    total++;
    if (got !== want)
      $display("FAIL %s[%0d]: got rej=%b disp=%b item=%0d nout=%b credit=%0d, want rej=%b disp=%b item=%0d nout=%b credit=%0d",
               name, idx, got.rej, got.disp, got.item, got.nout, got.cred,
               want.rej, want.disp, want.item, want.nout, want.cred);
    else
      passed++;
  endtask

  task automatic idle_step(input string name, input int idx, input logic nout, input logic [3:0] cred);
    apply(name, idx, mk(0,0,0,0,0,0,0, 0,0,0,nout,cred));
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset = 1'b1; nickel_in = 0; dime_in = 0; quarter_in = 0;
    sel_valid = 0; sel = 0; cancel = 0;

    //          rst n d q sv s cn | rej disp item nout cred
    // reset state, including a coin offered during reset
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,0,0,1,0,0,0, 0,0,0,0, 0));
    // item 0 (price 4): select, dime, dime -> single dispense, no change
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0));
    vecs.push_back(mk(0,0,0,0,1,0,0, 0,0,0,0, 0));
    vecs.push_back(mk(0,0,1,0,0,0,0, 0,0,0,0, 2));
    vecs.push_back(mk(0,0,1,0,0,0,0, 0,0,0,0, 4));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0, 4));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0));
    // item 2 (price 6): quarter, dime -> dispense then one nickel
    vecs.push_back(mk(0,0,0,0,1,2,0, 0,0,0,0, 0));
    vecs.push_back(mk(0,0,0,1,0,0,0, 0,0,0,0, 5));
    vecs.push_back(mk(0,0,1,0,0,0,0, 0,0,0,0, 7));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,1,2,0, 7));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,1, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0));
    // climb to 14, over-limit quarter rejected, nickel to 15, nickel at 15 rejected
    vecs.push_back(mk(0,0,0,1,0,0,0, 0,0,0,0, 5));
    vecs.push_back(mk(0,0,0,1,0,0,0, 0,0,0,0, 10));
    vecs.push_back(mk(0,0,1,0,0,0,0, 0,0,0,0, 12));
    vecs.push_back(mk(0,0,1,0,0,0,0, 0,0,0,0, 14));
    vecs.push_back(mk(0,0,0,1,0,0,0, 1,0,0,0, 14));
    vecs.push_back(mk(0,1,0,0,0,0,0, 0,0,0,0, 15));
    vecs.push_back(mk(0,1,0,0,0,0,0, 1,0,0,0, 15));
    // out-of-range select ignored, then item 1 (price 5) -> 10 nickels of change
    vecs.push_back(mk(0,0,0,0,1,3,0, 0,0,0,0, 15));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 15));
    vecs.push_back(mk(0,0,0,0,1,1,0, 0,0,0,0, 15));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,1,1,0, 15));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 10));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,1, 9));
    // a nickel inserted during CHANGE is rejected
    vecs.push_back(mk(0,1,0,0,0,0,0, 1,0,0,1, 8));
    for (int c = 7; c >= 0; c--)
      vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,1, 4'(c)));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0));
    // simultaneous coins: only the highest counts, reject pulses
    vecs.push_back(mk(0,1,1,0,0,0,0, 1,0,0,0, 2));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 2));
    vecs.push_back(mk(0,1,0,1,0,0,0, 1,0,0,0, 7));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 7));
    // item 0 with credit 7 -> dispense, enter CHANGE owing 3
    vecs.push_back(mk(0,0,0,0,1,0,0, 0,0,0,0, 7));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0, 7));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 3));

    for (int i = 0; i < vecs.size(); i++) apply("vec", i, vecs[i]);

    // reset mid-CHANGE with 3 nickels owed: everything clears, no further payout
    apply("rst_change", 0, mk(1,0,0,0,0,0,0, 0,0,0,0, 0));
    for (int i = 1; i < 5; i++) idle_step("rst_change", i, 1'b0, 4'd0);

`ifdef VEND_REFUND_EN
    // cancel in IDLE is ignored; credit 3 then cancel -> three refund nickels
    apply("refund", 0, mk(0,0,0,0,0,0,1, 0,0,0,0, 0));
    apply("refund", 1, mk(0,1,0,0,0,0,0, 0,0,0,0, 1));
    apply("refund", 2, mk(0,0,1,0,0,0,0, 0,0,0,0, 3));
    apply("refund", 3, mk(0,0,0,0,0,0,1, 0,0,0,0, 3));
    idle_step("refund", 4, 1'b1, 4'd2);
    idle_step("refund", 5, 1'b1, 4'd1);
    idle_step("refund", 6, 1'b1, 4'd0);
    idle_step("refund", 7, 1'b0, 4'd0);
    // cancel wins over a same-cycle vend condition
    apply("refund_prio", 0, mk(0,0,0,0,1,0,0, 0,0,0,0, 0));
    apply("refund_prio", 1, mk(0,0,1,0,0,0,0, 0,0,0,0, 2));
    apply("refund_prio", 2, mk(0,0,1,0,0,0,0, 0,0,0,0, 4));
    apply("refund_prio", 3, mk(0,0,0,0,0,0,1, 0,0,0,0, 4));
    idle_step("refund_prio", 4, 1'b1, 4'd3);
    idle_step("refund_prio", 5, 1'b1, 4'd2);
    idle_step("refund_prio", 6, 1'b1, 4'd1);
    idle_step("refund_prio", 7, 1'b1, 4'd0);
    idle_step("refund_prio", 8, 1'b0, 4'd0);
    idle_step("refund_prio", 9, 1'b0, 4'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
